// File: rtl/unified_mem_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto one single-port memory.
// Data requests win by default, and a streak limit keeps instruction fetch from starving.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                grant_owner
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
  localparam int unsigned LAT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;
  logic [LAT_W-1:0]    wait_cnt, wait_cnt_nxt;
  logic                pick_data;
  logic                owner_nxt;
  logic                mem_en_nxt, mem_we_nxt;
  logic [BE_W-1:0]     mem_be_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [DATA_W-1:0]   mem_wdata_nxt;
  logic                if_ack_nxt, d_ack_nxt, busy_nxt;
  logic [DATA_W-1:0]   if_rdata_nxt, d_rdata_nxt;

  // Next-state and next-output logic; every register holds unless a state updates it.
  always_comb begin
    state_nxt     = state;
    streak_nxt    = streak;
    wait_cnt_nxt  = wait_cnt;
    pick_data     = 1'b0;
    owner_nxt     = grant_owner;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = mem_we;
    mem_be_nxt    = mem_be;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_ack_nxt    = 1'b0;
    d_ack_nxt     = 1'b0;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;

    unique case (state)
      ST_IDLE: begin
        if (if_req || d_req) begin
          pick_data  = d_req && !(if_req && (streak == STREAK_W'(MAX_STREAK)));
          mem_en_nxt = 1'b1;
          state_nxt  = ST_ISSUE;
          if (pick_data) begin
            owner_nxt     = 1'b1;
            mem_we_nxt    = d_we;
            mem_be_nxt    = d_be;
            mem_addr_nxt  = d_addr;
            mem_wdata_nxt = d_wdata;
            // Only a grant that makes a fetch wait counts towards the streak.
            if (!if_req) begin
              streak_nxt = '0;
            end else if (streak != STREAK_W'(MAX_STREAK)) begin
              streak_nxt = streak + STREAK_W'(1);
            end
          end else begin
            owner_nxt     = 1'b0;
            mem_we_nxt    = 1'b0;
            mem_be_nxt    = '1;
            mem_addr_nxt  = if_addr;
            mem_wdata_nxt = '0;
            streak_nxt    = '0;
          end
        end
      end
      ST_ISSUE: begin
        wait_cnt_nxt = LAT_W'(MEM_LAT);
        state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt <= LAT_W'(1)) begin
          wait_cnt_nxt = '0;
          state_nxt    = ST_RESP;
          if (grant_owner) begin
            d_ack_nxt = 1'b1;
            if (!mem_we) begin
              d_rdata_nxt = mem_rdata;
            end
          end else begin
            if_ack_nxt   = 1'b1;
            if_rdata_nxt = mem_rdata;
          end
        end else begin
          wait_cnt_nxt = wait_cnt - LAT_W'(1);
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      streak      <= '0;
      wait_cnt    <= '0;
      grant_owner <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      streak      <= streak_nxt;
      wait_cnt    <= wait_cnt_nxt;
      grant_owner <= owner_nxt;
      mem_en      <= mem_en_nxt;
      mem_we      <= mem_we_nxt;
      mem_be      <= mem_be_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wdata   <= mem_wdata_nxt;
      if_ack      <= if_ack_nxt;
      d_ack       <= d_ack_nxt;
      if_rdata    <= if_rdata_nxt;
      d_rdata     <= d_rdata_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a table of single transactions at MEM_LAT=1,
// plus reset, streak, MEM_LAT=3 and mid-transaction reset sequences.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req1, d_req1, if_req3, d_req3;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] if_addr, d_addr, d_wdata;

  logic        if_ack1, d_ack1, mem_en1, mem_we1, busy1, go1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  mem_be1;
  logic        if_ack3, d_ack3, mem_en3, mem_we3, busy3, go3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [3:0]  mem_be3;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_if, exp_d;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_STREAK(4)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr), .if_ack(if_ack1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .busy(busy1), .grant_owner(go1)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_STREAK(4)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .busy(busy3), .grant_owner(go3)
  );

  // Memory contents: one fixed instruction, everything else derived from the address.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0050_0093;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Read data is garbage until MEM_LAT cycles after the strobe.
  logic [1:0]  cnt1, cnt3;
  logic        pend1 = 1'b0, pend3 = 1'b0;
  logic [31:0] a1, a3;
  always @(posedge clk) begin
    if (mem_en1) begin pend1 <= 1'b1; cnt1 <= 2'd0; a1 <= mem_addr1; end
    else if (cnt1 != 2'd0) cnt1 <= cnt1 - 2'd1;
    if (mem_en3) begin pend3 <= 1'b1; cnt3 <= 2'd2; a3 <= mem_addr3; end
    else if (cnt3 != 2'd0) cnt3 <= cnt3 - 2'd1;
  end
  assign mem_rdata1 = (pend1 && cnt1 == 2'd0) ? mem_model(a1) : 32'hBAD0_BAD0;
  assign mem_rdata3 = (pend3 && cnt3 == 2'd0) ? mem_model(a3) : 32'hBAD0_BAD0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  // One transaction on dut1 from IDLE; starts and ends at a negedge.
  task automatic run_vec(input int i, input vec_t v);
    d_we = v.we; d_be = v.be; d_wdata = v.wdata;
    if (v.is_d) begin d_addr = v.addr; d_req1 = 1'b1; end
    else begin if_addr = v.addr; if_req1 = 1'b1; end
    if (v.is_d && !v.we) exp_d = v.exp_rdata;
    if (!v.is_d) exp_if = v.exp_rdata;
    @(negedge clk);
    check($sformatf("v%0d_issue_en", i), 64'(mem_en1), 64'd1);
    check($sformatf("v%0d_issue_addr", i), 64'(mem_addr1), 64'(v.addr));
    check($sformatf("v%0d_issue_we", i), 64'(mem_we1), 64'(v.exp_we));
    check($sformatf("v%0d_issue_be", i), 64'(mem_be1), 64'(v.exp_be));
    check($sformatf("v%0d_issue_wdata", i), 64'(mem_wdata1), 64'(v.exp_wdata));
    check($sformatf("v%0d_owner", i), 64'(go1), 64'(v.is_d));
    check($sformatf("v%0d_busy", i), 64'(busy1), 64'd1);
    @(negedge clk);
    check($sformatf("v%0d_wait_en", i), 64'(mem_en1), 64'd0);
    check($sformatf("v%0d_wait_ack", i), 64'({if_ack1, d_ack1}), 64'd0);
    @(negedge clk);
    check($sformatf("v%0d_resp_ack", i), 64'({if_ack1, d_ack1}), v.is_d ? 64'd1 : 64'd2);
    check($sformatf("v%0d_if_rdata", i), 64'(if_rdata1), 64'(exp_if));
    check($sformatf("v%0d_d_rdata", i), 64'(d_rdata1), 64'(exp_d));
    check($sformatf("v%0d_resp_addr", i), 64'(mem_addr1), 64'(v.addr));
    if_req1 = 1'b0; d_req1 = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_idle", i), 64'({busy1, if_ack1, d_ack1, mem_en1}), 64'd0);
    check($sformatf("v%0d_idle_addr", i), 64'(mem_addr1), 64'(v.addr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    logic exp_own [10];

    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h1111_2222, 1'b0, 4'hF, 32'h0, 32'h0050_0093};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 4'h3, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0BAD_F00D, 1'b0, 4'hF, 32'h0BAD_F00D, 32'h5A5A_0020};
    vecs[3] = '{1'b0, 1'b1, 4'h5, 32'h0000_0024, 32'hFFFF_FFFF, 1'b0, 4'hF, 32'h0, 32'h5A5A_0024};
    vecs[4] = '{1'b1, 1'b1, 4'hC, 32'h0000_0104, 32'h1234_5678, 1'b1, 4'hC, 32'h1234_5678, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 4'h1, 32'h0000_0200, 32'h0, 1'b0, 4'h1, 32'h0, 32'h5A5A_0200};
    exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset held with both requests high.
    reset = 1'b1; if_req1 = 1'b1; d_req1 = 1'b1; if_req3 = 1'b0; d_req3 = 1'b0;
    d_we = 1'b0; d_be = 4'hF; d_addr = 32'h40; d_wdata = 32'h0; if_addr = 32'h10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst%0d_ctrl", c),
            64'({mem_en1, busy1, if_ack1, d_ack1, go1, mem_we1, mem_be1}), 64'd0);
      check($sformatf("rst%0d_addr", c), 64'({mem_addr1, mem_wdata1}), 64'd0);
      check($sformatf("rst%0d_rdata", c), 64'({if_rdata1, d_rdata1}), 64'd0);
    end
    check("rst_dut3", 64'({mem_en3, busy3, if_ack3, d_ack3, go3, mem_addr3}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("first_owner", 64'(go1), 64'd1);
    check("first_en", 64'(mem_en1), 64'd1);
    check("first_addr", 64'(mem_addr1), 64'h40);
    if_req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("first_ack", 64'({if_ack1, d_ack1}), 64'd1);
    check("first_rdata", 64'(d_rdata1), 64'h5A5A_0040);
    d_req1 = 1'b0;
    @(negedge clk);
    exp_d = 32'h5A5A_0040; exp_if = 32'h0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Both requesters continuously active: fetch gets every fifth grant.
    d_we = 1'b0; d_be = 4'hF; d_addr = 32'h20; d_wdata = 32'h0; if_addr = 32'h24;
    if_req1 = 1'b1; d_req1 = 1'b1;
    for (int g = 0; g < 10; g++) begin
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (mem_en1) begin seen = 1'b1; break; end
      end
      check($sformatf("streak_grant%0d", g), seen ? 64'(go1) : 64'hDEAD, 64'(exp_own[g]));
    end
    // Requests withdrawn while the last fetch is in flight; it must still complete.
    if_req1 = 1'b0; d_req1 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if_ack1) begin seen = 1'b1; break; end
    end
    check("drop_req_ack", 64'(seen), 64'd1);
    check("streak_if_rdata", 64'(if_rdata1), 64'h5A5A_0024);
    check("streak_d_rdata", 64'(d_rdata1), 64'h5A5A_0020);
    @(negedge clk);
    check("streak_idle", 64'({busy1, if_ack1, d_ack1}), 64'd0);

    // MEM_LAT=3 load.
    d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200; d_req3 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("lat3_en_k%0d", k), 64'(mem_en3), 64'(k == 1));
      if (k <= 5) check($sformatf("lat3_addr_k%0d", k), 64'(mem_addr3), 64'h200);
      check($sformatf("lat3_ack_k%0d", k), 64'({if_ack3, d_ack3}), (k == 5) ? 64'd1 : 64'd0);
      if (k == 5) begin
        check("lat3_rdata", 64'(d_rdata3), 64'h5A5A_0200);
        d_req3 = 1'b0;
      end
      if (k == 6) check("lat3_idle", 64'(busy3), 64'd0);
    end

    // Reset during WAIT of a load aborts it without an ack.
    d_addr = 32'h204; d_req3 = 1'b1;
    @(negedge clk);
    check("abort_issue", 64'(mem_en3), 64'd1);
    @(negedge clk);
    check("abort_wait_busy", 64'({busy3, mem_en3}), 64'd2);
    reset = 1'b1; d_req3 = 1'b0;
    @(negedge clk);
    check("abort_ctrl", 64'({d_ack3, if_ack3, busy3, mem_en3, go3, mem_we3, mem_be3}), 64'd0);
    check("abort_data", 64'({d_rdata3, mem_addr3}), 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("abort_quiet%0d", c), 64'({d_ack3, if_ack3, busy3, mem_en3}), 64'd0);
    end
    if_addr = 32'h10; if_req3 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("post_en_k%0d", k), 64'(mem_en3), 64'(k == 1));
      check($sformatf("post_ack_k%0d", k), 64'({if_ack3, d_ack3}), (k == 5) ? 64'd2 : 64'd0);
    end
    check("post_if_rdata", 64'(if_rdata3), 64'h0050_0093);
    if_req3 = 1'b0;
    @(negedge clk);
    check("post_idle", 64'(busy3), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction fetch path and the load/store path of the RISC-V core.
- Arbitrates between the two requesters and runs one memory transaction at a time through an IDLE/ISSUE/WAIT/RESP state machine.
- Returns read data to the granted requester with a one-cycle ack.
- Data requests have priority; a streak counter prevents instruction-fetch starvation.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MEM_LAT, 1, cycles from mem_en until mem_rdata is valid; legal range 1..4.
- MAX_STREAK, 4, maximum consecutive data grants while an ifetch request waits.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  instruction fetch read request, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle completion pulse for fetch
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  load/store request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  store byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle completion pulse for data
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_be  out  DATA_W/8  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  transaction in progress (state != IDLE)
- grant_owner  out  1  last winner: 0 = ifetch, 1 = data

Behaviour:
- Reset (synchronous): state IDLE, streak = 0; every output = 0, including if_rdata, d_rdata and grant_owner.
- All outputs are registered.
- IDLE:
  - Samples if_req and d_req.
  - If either is high, picks a winner and latches its addr/we/be/wdata into mem_* registers.
  - Updates grant_owner, then goes to ISSUE.
  - No request: stays in IDLE.
- Arbitration:
  - Only d_req: data wins. Only if_req: ifetch wins.
  - Both: data wins unless streak == MAX_STREAK, in which case ifetch wins.
- Streak counter:
  - Increments on a data grant made while if_req is high.
  - Clears on any ifetch grant.
  - Clears on a data grant made while if_req is low.
  - Saturates at MAX_STREAK.
- Ifetch grant fields: mem_we = 0, mem_be = all ones, mem_wdata = 0.
- Data grant fields: mem_we = d_we, mem_be = d_be, mem_wdata = d_wdata.
- ISSUE: mem_en = 1 for exactly this one cycle; mem_we is valid only together with mem_en. Next state WAIT, wait counter = MEM_LAT.
- WAIT:
  - Lasts MEM_LAT cycles.
  - On the last WAIT cycle, mem_rdata is captured into the granted port's rdata register; for stores, nothing is captured.
  - Next state RESP.
- RESP:
  - The granted port's ack = 1 for one cycle.
  - The other ack stays 0, and the other port's rdata is unchanged.
  - Next state IDLE.
- Stability: mem_addr, mem_we, mem_be and mem_wdata hold from ISSUE through RESP and keep their values while in IDLE.
- Latency:
  - A request sampled in IDLE at cycle T0 gives mem_en at T0+1 and ack at T0+MEM_LAT+2.
  - Loads and stores have identical timing.
  - Peak throughput is one transaction per MEM_LAT+3 cycles.
- Requester protocol:
  - Hold req and all request fields stable until ack.
  - On the cycle after ack, either deassert req or present the next request.
  - Requests are ignored outside IDLE.
  - If req drops before ack, the arbiter still completes the transaction and pulses ack.
- if_rdata and d_rdata each hold their last value until their own next load/fetch completion.
- Reset mid-transaction: the next edge returns to IDLE with all outputs 0. No ack is issued for the aborted transaction and there is no pending memory strobe.
- Undefined behaviour: MEM_LAT outside 1..4 and request fields changing while req is high.

Test Plan:
- Reset held 3 cycles with both reqs high -> all outputs 0, busy = 0, no mem_en; after release, data is granted first.
- MEM_LAT=1, if_req with if_addr=0x0000_0010, memory returns 0x0050_0093:
  - mem_en=1, mem_we=0, mem_be=4'hF, mem_addr=0x10 at T0+1.
  - if_ack=1 with if_rdata=0x0050_0093 at T0+3.
  - d_ack stays 0.
- Store with d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xDEAD_BEEF:
  - mem_en=1, mem_we=1 with those values at T0+1.
  - d_ack at T0+3.
  - d_rdata and if_rdata unchanged.
- MAX_STREAK=4, both reqs held high, each requester re-requesting after every ack -> grant_owner sequence D,D,D,D,I,D,D,D,D,I.
- MEM_LAT=3, load at d_addr=0x200 -> mem_en only at T0+1, mem_addr=0x200 stable T0+1..T0+5, d_ack at T0+5.
- reset pulsed during WAIT of a load:
  - No d_ack, busy=0, mem_en=0 next cycle.
  - A following if_req completes normally with ack at T0+MEM_LAT+2.
